// File: rtl/lcd_write_scheduler.sv
// lcd_write_scheduler
// Shares the Spartan-3E character LCD (4-bit HD44780 bus) between two
// requesters. Byte writes are arbitrated round-robin, split into two nibble
// transfers with E/RS/DB timing, and followed by the command execution delay.
//
// Build option: define LCD_INIT_SEQ_EN to run the HD44780 power-on init
// sequence after Reset. oReady stays low until the sequence has finished.
//
// Ports
//   Clock                   system clock, 50 MHz
//   Reset                   synchronous, active-high
//   iReq0/iReq1             level write request, held until the matching ack
//   iRS0/iRS1               0 = command, 1 = data
//   iData0/iData1           byte to write
//   oAck0/oAck1             one-cycle pulse: byte captured, inputs may change
//   oBusy                   transfer or post-write delay in progress
//   oReady                  LCD accepts requests
//   oLCD_Enabled            LCD E
//   oLCD_RegisterSelect     LCD RS
//   oLCD_ReadWrite          LCD RW, always 0
//   oLCD_StrataFlashControl always 1, keeps the flash off the shared DB lines
//   oLCD_Data               LCD DB[7:4]
//
// State    | meaning
// IDLE     | waiting for a request (or the next init byte)
// SET_HI   | high nibble on DB, E low, setup time
// EN_HI    | E high for the high nibble
// HLD_HI   | E low, DB/RS held
// GAP      | delay between the two nibbles
// SET_LO   | low nibble on DB, E low, setup time
// EN_LO    | E high for the low nibble
// HLD_LO   | E low, DB/RS held
// WAIT     | execution delay (long for Clear/Home)
// INIT_LD  | first cycle after Reset, loads the power-on wait
// INIT_DLY | init wait, before or after a lone nibble
// INIT_SET | init nibble setup
// INIT_EN  | init nibble E high
// INIT_HLD | init nibble hold
module lcd_write_scheduler #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 1,
    parameter int T_NIB   = 50,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq0,
    input  logic       iReq1,
    input  logic       iRS0,
    input  logic       iRS1,
    input  logic [7:0] iData0,
    input  logic [7:0] iData1,
    output logic       oAck0,
    output logic       oAck1,
    output logic       oBusy,
    output logic       oReady,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] SET_HI = 4'd1;
    localparam logic [3:0] EN_HI  = 4'd2;
    localparam logic [3:0] HLD_HI = 4'd3;
    localparam logic [3:0] GAP    = 4'd4;
    localparam logic [3:0] SET_LO = 4'd5;
    localparam logic [3:0] EN_LO  = 4'd6;
    localparam logic [3:0] HLD_LO = 4'd7;
    localparam logic [3:0] WAIT   = 4'd8;
`ifdef LCD_INIT_SEQ_EN
    localparam logic [3:0] INIT_LD  = 4'd9;
    localparam logic [3:0] INIT_DLY = 4'd10;
    localparam logic [3:0] INIT_SET = 4'd11;
    localparam logic [3:0] INIT_EN  = 4'd12;
    localparam logic [3:0] INIT_HLD = 4'd13;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A delay of n cycles loads n-1 and leaves the state when the count hits 0.
    function automatic logic [CNT_W-1:0] ld(input int n);
        return CNT_W'(n - 1);
    endfunction

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rrPtr;
    logic             rsLat;
    logic [7:0]       byteLat;
    logic             lcdE;
    logic             lcdRs;
    logic [3:0]       lcdData;
    logic             busyReg;
    logic             readyReg;
`ifdef LCD_INIT_SEQ_EN
    logic [2:0]       initStep;   // lone init nibbles already sent
    logic [1:0]       initByte;   // init command bytes already sent
`endif

    logic       grantPort;
    logic       grantValid;
    logic       issue;
    logic       selRs;
    logic [7:0] selByte;
    logic       cntZero;
    logic       isLong;

    always_comb begin
        grantPort  = (iReq0 && iReq1) ? rrPtr : iReq1;
        grantValid = (state == IDLE) && readyReg && (iReq0 || iReq1);
        selRs      = grantPort ? iRS1 : iRS0;
        selByte    = grantPort ? iData1 : iData0;
        issue      = grantValid;
`ifdef LCD_INIT_SEQ_EN
        // Init command bytes reuse the normal byte path without an ack.
        if ((state == IDLE) && !readyReg) begin
            issue = 1'b1;
            selRs = 1'b0;
            case (initByte)
                2'd0:    selByte = 8'h28;
                2'd1:    selByte = 8'h06;
                2'd2:    selByte = 8'h0C;
                default: selByte = 8'h01;
            endcase
        end
`endif
    end

    assign cntZero = (cnt == '0);
    assign isLong  = !rsLat && ((byteLat == 8'h01) || (byteLat == 8'h02) || (byteLat == 8'h03));

    assign oAck0                   = grantValid && !grantPort;
    assign oAck1                   = grantValid && grantPort;
    assign oBusy                   = busyReg;
    assign oReady                  = readyReg;
    assign oLCD_Enabled            = lcdE;
    assign oLCD_RegisterSelect     = lcdRs;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_Data               = lcdData;

    always_ff @(posedge Clock) begin
        if (Reset) begin
`ifdef LCD_INIT_SEQ_EN
            state    <= INIT_LD;
            initStep <= 3'd0;
            initByte <= 2'd0;
`else
            state    <= IDLE;
`endif
            cnt      <= '0;
            rrPtr    <= 1'b0;
            rsLat    <= 1'b0;
            byteLat  <= 8'h00;
            lcdE     <= 1'b0;
            lcdRs    <= 1'b0;
            lcdData  <= 4'h0;
            busyReg  <= 1'b0;
            readyReg <= 1'b0;
        end else begin
`ifndef LCD_INIT_SEQ_EN
            readyReg <= 1'b1;
`endif
            if ((state != IDLE) && !cntZero) begin
                cnt <= cnt - CNT_ONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (issue) begin
                            state   <= SET_HI;
                            cnt     <= ld(T_SETUP);
                            rsLat   <= selRs;
                            byteLat <= selByte;
                            lcdRs   <= selRs;
                            lcdData <= selByte[7:4];
                            busyReg <= 1'b1;
                            if (grantValid) rrPtr <= ~grantPort;
                        end
                    end
                    SET_HI: begin
                        state <= EN_HI;
                        cnt   <= ld(T_EN);
                        lcdE  <= 1'b1;
                    end
                    EN_HI: begin
                        state <= HLD_HI;
                        cnt   <= ld(T_HOLD);
                        lcdE  <= 1'b0;
                    end
                    HLD_HI: begin
                        state <= GAP;
                        cnt   <= ld(T_NIB);
                    end
                    GAP: begin
                        state   <= SET_LO;
                        cnt     <= ld(T_SETUP);
                        lcdData <= byteLat[3:0];
                    end
                    SET_LO: begin
                        state <= EN_LO;
                        cnt   <= ld(T_EN);
                        lcdE  <= 1'b1;
                    end
                    EN_LO: begin
                        state <= HLD_LO;
                        cnt   <= ld(T_HOLD);
                        lcdE  <= 1'b0;
                    end
                    HLD_LO: begin
                        state <= WAIT;
                        cnt   <= isLong ? ld(T_LONG) : ld(T_EXEC);
                    end
                    WAIT: begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
                        if (!readyReg) begin
                            initByte <= initByte + 2'd1;
                            if (initByte == 2'd3) readyReg <= 1'b1;
                        end
`endif
                    end
`ifdef LCD_INIT_SEQ_EN
                    INIT_LD: begin
                        state   <= INIT_DLY;
                        cnt     <= ld(750000);
                        busyReg <= 1'b1;
                    end
                    INIT_DLY: begin
                        if (initStep == 3'd4) begin
                            state <= IDLE;
                        end else begin
                            state   <= INIT_SET;
                            cnt     <= ld(T_SETUP);
                            lcdRs   <= 1'b0;
                            lcdData <= (initStep == 3'd3) ? 4'h2 : 4'h3;
                        end
                    end
                    INIT_SET: begin
                        state <= INIT_EN;
                        cnt   <= ld(T_EN);
                        lcdE  <= 1'b1;
                    end
                    INIT_EN: begin
                        state <= INIT_HLD;
                        cnt   <= ld(T_HOLD);
                        lcdE  <= 1'b0;
                    end
                    INIT_HLD: begin
                        state    <= INIT_DLY;
                        initStep <= initStep + 3'd1;
                        case (initStep)
                            3'd0:    cnt <= ld(205000);
                            3'd1:    cnt <= ld(5000);
                            default: cnt <= ld(2000);
                        endcase
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
module tb_lcd_write_scheduler;

    localparam int T_SETUP = 2;
    localparam int T_EN    = 12;
    localparam int T_HOLD  = 1;
    localparam int T_NIB   = 50;
    localparam int T_EXEC  = 2000;
    localparam int T_LONG  = 82000;
    localparam int BYTE_NORMAL = 2 * (T_SETUP + T_EN + T_HOLD) + T_NIB + T_EXEC;  // 2080
    localparam int BYTE_LONG   = 2 * (T_SETUP + T_EN + T_HOLD) + T_NIB + T_LONG;  // 82080

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iReq0 = 1'b0, iReq1 = 1'b0, iRS0 = 1'b0, iRS1 = 1'b0;
    logic [7:0] iData0 = 8'h00, iData1 = 8'h00;
    logic       oAck0, oAck1, oBusy, oReady;
    logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    int checks = 0;
    int failures = 0;
    int constBad = 0;

    // Results of the most recent measure_byte call.
    int         mLat, mE1, mE2, mBusy, mAfter, mAck;
    logic [3:0] mNib1, mNib2;
    logic       mRs1, mRs2, mBusyStart;
    bit         mTimeout;

    lcd_write_scheduler dut (
        .Clock(Clock),
        .Reset(Reset),
        .iReq0(iReq0),
        .iReq1(iReq1),
        .iRS0(iRS0),
        .iRS1(iRS1),
        .iData0(iData0),
        .iData1(iData1),
        .oAck0(oAck0),
        .oAck1(oAck1),
        .oBusy(oBusy),
        .oReady(oReady),
        .oLCD_Enabled(oLCD_Enabled),
        .oLCD_RegisterSelect(oLCD_RegisterSelect),
        .oLCD_ReadWrite(oLCD_ReadWrite),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
        .oLCD_Data(oLCD_Data)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) constBad++;
    end

    // Called in the sample slot of a grant cycle; follows the byte until oBusy drops.
    // k counts cycles after the grant cycle.
    task automatic measure_byte(input bit dropReq);
        logic prevE;
        int   pulses;
        int   fallK;
        prevE = 1'b0; pulses = 0; fallK = 0;
        mLat = 0; mE1 = 0; mE2 = 0; mBusy = 0; mAfter = 0; mAck = 0;
        mNib1 = 4'hx; mNib2 = 4'hx; mRs1 = 1'bx; mRs2 = 1'bx; mBusyStart = 1'b0;
        mTimeout = 1'b1;
        for (int k = 1; k <= 90000; k++) begin
            @(posedge Clock); #1;
            if (k == 1) begin
                mBusyStart = oBusy;
                if (dropReq) begin
                    iReq0 = 1'b0;
                    iReq1 = 1'b0;
                end
            end
            if (oBusy && (oAck0 || oAck1)) mAck++;
            if (oLCD_Enabled && !prevE) begin
                pulses++;
                if (pulses == 1) begin
                    mLat = k; mNib1 = oLCD_Data; mRs1 = oLCD_RegisterSelect;
                end else begin
                    mNib2 = oLCD_Data; mRs2 = oLCD_RegisterSelect;
                end
            end
            if (oLCD_Enabled) begin
                if (pulses == 1) mE1++;
                else mE2++;
            end
            if (!oLCD_Enabled && prevE && pulses == 2) fallK = k;
            prevE = oLCD_Enabled;
            if (oBusy) begin
                mBusy++;
            end else begin
                mAfter = k - fallK;
                mTimeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        iReq0 = 1'b1; iRS0 = 1'b0; iData0 = 8'h80;
        iReq1 = 1'b1; iRS1 = 1'b0; iData1 = 8'h01;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if ({oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data} !== 6'b0) begin
            failures++;
            $display("FAIL reset_lcd_pins got E=%0b RS=%0b DB=%h required 0,0,0",
                     oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data);
        end
        checks++;
        if ({oAck0, oAck1, oBusy, oReady} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status got ack0=%0b ack1=%0b busy=%0b ready=%0b required all 0",
                     oAck0, oAck1, oBusy, oReady);
        end
        Reset = 1'b0;
    endtask

    // Both requests held from reset: port0 (0x80 cmd), port1 (0x01 Clear), grants 0,1,0,1.
    task automatic test_contention_long;
        @(posedge Clock); #1;
        checks++;
        if (oReady !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got %0b required 1", oReady);
        end
        checks++;
        if ({oAck0, oAck1} !== 2'b10) begin
            failures++;
            $display("FAIL grant1_port0 got ack0=%0b ack1=%0b required 1,0", oAck0, oAck1);
        end

        measure_byte(1'b0);
        checks++;
        if (mTimeout !== 1'b0) begin
            failures++;
            $display("FAIL byte80_timeout got busy stuck required release");
        end
        checks++;
        if (mBusyStart !== 1'b1 || mLat != 1 + T_SETUP) begin
            failures++;
            $display("FAIL byte80_latency got busy=%0b lat=%0d required 1,%0d", mBusyStart, mLat, 1 + T_SETUP);
        end
        checks++;
        if (mE1 != T_EN || mE2 != T_EN) begin
            failures++;
            $display("FAIL byte80_e_width got %0d,%0d required %0d", mE1, mE2, T_EN);
        end
        checks++;
        if (mNib1 !== 4'h8 || mNib2 !== 4'h0 || mRs1 !== 1'b0 || mRs2 !== 1'b0) begin
            failures++;
            $display("FAIL byte80_bus got DB=%h,%h RS=%0b,%0b required 8,0 RS=0,0", mNib1, mNib2, mRs1, mRs2);
        end
        checks++;
        if (mBusy != BYTE_NORMAL || mAfter != T_HOLD + T_EXEC) begin
            failures++;
            $display("FAIL byte80_duration got busy=%0d after_fall=%0d required %0d,%0d",
                     mBusy, mAfter, BYTE_NORMAL, T_HOLD + T_EXEC);
        end
        checks++;
        if (mAck != 0) begin
            failures++;
            $display("FAIL byte80_ack_while_busy got %0d required 0", mAck);
        end
        checks++;
        if ({oAck0, oAck1} !== 2'b01) begin
            failures++;
            $display("FAIL grant2_port1 got ack0=%0b ack1=%0b required 0,1", oAck0, oAck1);
        end

        measure_byte(1'b0);
        checks++;
        if (mTimeout !== 1'b0) begin
            failures++;
            $display("FAIL clear_timeout got busy stuck required release");
        end
        checks++;
        if (mNib1 !== 4'h0 || mNib2 !== 4'h1 || mRs1 !== 1'b0) begin
            failures++;
            $display("FAIL clear_bus got DB=%h,%h RS=%0b required 0,1 RS=0", mNib1, mNib2, mRs1);
        end
        checks++;
        if (mBusy != BYTE_LONG || mAfter != T_HOLD + T_LONG) begin
            failures++;
            $display("FAIL clear_duration got busy=%0d after_fall=%0d required %0d,%0d",
                     mBusy, mAfter, BYTE_LONG, T_HOLD + T_LONG);
        end
        checks++;
        if ({oAck0, oAck1} !== 2'b10) begin
            failures++;
            $display("FAIL grant3_port0 got ack0=%0b ack1=%0b required 1,0", oAck0, oAck1);
        end

        measure_byte(1'b0);
        checks++;
        if (mBusy != BYTE_NORMAL || mTimeout !== 1'b0) begin
            failures++;
            $display("FAIL byte80_again_duration got busy=%0d timeout=%0b required %0d,0", mBusy, mTimeout, BYTE_NORMAL);
        end
        checks++;
        if ({oAck0, oAck1} !== 2'b01) begin
            failures++;
            $display("FAIL grant4_port1 got ack0=%0b ack1=%0b required 0,1", oAck0, oAck1);
        end
    endtask

    // Continues the 4th grant: cycle 70 after grant lies inside EN_LO (cycles 68..79).
    task automatic test_reset_mid_op;
        for (int k = 1; k <= 70; k++) begin
            @(posedge Clock); #1;
        end
        checks++;
        if (oLCD_Enabled !== 1'b1) begin
            failures++;
            $display("FAIL midop_in_en_lo got E=%0b required 1", oLCD_Enabled);
        end
        Reset = 1'b1;
        iReq0 = 1'b0;
        iReq1 = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if ({oLCD_Enabled, oBusy, oAck0, oAck1} !== 4'b0000) begin
            failures++;
            $display("FAIL midop_abort got E=%0b busy=%0b ack0=%0b ack1=%0b required all 0",
                     oLCD_Enabled, oBusy, oAck0, oAck1);
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if ({oReady, oBusy, oAck0, oAck1} !== 4'b1000) begin
            failures++;
            $display("FAIL midop_recover got ready=%0b busy=%0b ack0=%0b ack1=%0b required 1,0,0,0",
                     oReady, oBusy, oAck0, oAck1);
        end
    endtask

    task automatic test_single_write;
        iReq0 = 1'b1; iRS0 = 1'b1; iData0 = 8'h41;
        #1;
        checks++;
        if ({oAck0, oAck1} !== 2'b10) begin
            failures++;
            $display("FAIL single_ack got ack0=%0b ack1=%0b required 1,0", oAck0, oAck1);
        end
        measure_byte(1'b1);
        checks++;
        if (mTimeout !== 1'b0 || mLat != 1 + T_SETUP) begin
            failures++;
            $display("FAIL single_latency got lat=%0d timeout=%0b required %0d,0", mLat, mTimeout, 1 + T_SETUP);
        end
        checks++;
        if (mNib1 !== 4'h4 || mNib2 !== 4'h1 || mRs1 !== 1'b1 || mRs2 !== 1'b1) begin
            failures++;
            $display("FAIL single_bus got DB=%h,%h RS=%0b,%0b required 4,1 RS=1,1", mNib1, mNib2, mRs1, mRs2);
        end
        checks++;
        if (mE1 != T_EN || mE2 != T_EN) begin
            failures++;
            $display("FAIL single_e_width got %0d,%0d required %0d", mE1, mE2, T_EN);
        end
        checks++;
        if (mBusy != BYTE_NORMAL || mAfter != T_HOLD + T_EXEC || mAck != 0) begin
            failures++;
            $display("FAIL single_duration got busy=%0d after_fall=%0d acks=%0d required %0d,%0d,0",
                     mBusy, mAfter, mAck, BYTE_NORMAL, T_HOLD + T_EXEC);
        end
    endtask

    // Pointer now favours port1; a lone port0 request must still win.
    task automatic test_single_wins;
        iReq0 = 1'b1; iRS0 = 1'b1; iData0 = 8'h30;
        #1;
        checks++;
        if ({oAck0, oAck1} !== 2'b10) begin
            failures++;
            $display("FAIL lone_port0_wins got ack0=%0b ack1=%0b required 1,0", oAck0, oAck1);
        end
        @(posedge Clock); #1;
        iReq0 = 1'b0;
        checks++;
        if ({oBusy, oAck0, oLCD_Data} !== 6'b10_0011) begin
            failures++;
            $display("FAIL lone_port0_start got busy=%0b ack0=%0b DB=%h required 1,0,3", oBusy, oAck0, oLCD_Data);
        end
    endtask

    task automatic test_constants;
        checks++;
        if (constBad !== 0) begin
            failures++;
            $display("FAIL const_pins got %0d bad cycles required 0", constBad);
        end
    endtask

    initial begin
        test_reset();
        test_contention_long();
        test_reset_mid_op();
        test_single_write();
        test_single_wins();
        test_constants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
